cache_controller: RTL

- Fill/write side of the data cache: 2-way set-associative, 64 sets, 2 words per block, write-through, write-update, no-write-allocate.
- Sits between the MEM stage and the SRAM controller.
- Serves read hits in the same cycle. On a read miss it fetches the 64-bit block from SRAM and fills it into the victim way.
- Forwards every store to SRAM, and updates the cached copy when the store hits.
- Stalls the pipeline via ready while an SRAM transaction is in flight.

---
 rtl/cache_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// CacheController
//
// Fill/write side of the data cache: 2-way set-associative, 2 words per
// block, write-through, write-update, no-write-allocate. Read hits are served
// in the same cycle. A read miss fetches the whole 64-bit block from SRAM
// into the victim way. Every store is forwarded to SRAM, and the cached copy
// is updated when the store hits. While an SRAM transaction is in flight,
// ready is held low to stall the pipeline.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   mem_rd_en    : load request from the MEM stage
//   mem_wr_en    : store request from the MEM stage (wins over mem_rd_en)
//   address      : word address {tag, index, offset}
//   wdata        : store data
//   rdata        : load data, valid when ready=1 and mem_rd_en=1
//   ready        : 0 stalls the pipeline
//   sram_rd_en   : block read request to the SRAM controller
//   sram_wr_en   : word write request to the SRAM controller
//   sram_address : {tag, index, 0} for block reads, address for writes
//   sram_wdata   : store data forwarded to SRAM
//   sram_rdata   : block from SRAM, [31:0] word 0, [63:32] word 1
//   sram_ready   : one-cycle pulse marking transaction completion
// -----------------------------------------------------------------------------
module cache_controller #(
    parameter int SETS   = 64,
    parameter int TAG_W  = 11,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              sram_rd_en,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_address,
    output logic [31:0]       sram_wdata,
    input  logic [63:0]       sram_rdata,
    input  logic              sram_ready
);

    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_WAIT
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [63:0]      r_data0 [SETS];
    logic [63:0]      r_data1 [SETS];
    logic [TAG_W-1:0] r_tag0  [SETS];
    logic [TAG_W-1:0] r_tag1  [SETS];
    logic [SETS-1:0]  r_valid0;
    logic [SETS-1:0]  r_valid1;
    logic [SETS-1:0]  r_lru;

    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_index;
    logic             w_offset;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_hit;
    logic             w_victim;
    logic             w_fill;
    logic             w_rdHit;
    logic             w_wrHit;
    logic [31:0]      w_fillWord;

    assign w_tag    = address[ADDR_W-1 -: TAG_W];
    assign w_index  = address[IDX_W:1];
    assign w_offset = address[0];

    assign w_hit0 = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
    assign w_hit1 = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
    assign w_hit  = w_hit0 || w_hit1;

    // Empty ways are filled before anything valid is evicted; once both are
    // valid the LRU bit names the victim directly.
    assign w_victim = !r_valid0[w_index] ? 1'b0 :
                      !r_valid1[w_index] ? 1'b1 : r_lru[w_index];

    assign w_fill  = (r_state == RD_MISS) && sram_ready;
    assign w_rdHit = (r_state == IDLE) && mem_rd_en && !mem_wr_en && w_hit;
    assign w_wrHit = (r_state == WR_WAIT) && sram_ready && w_hit;

    assign w_fillWord = w_offset ? sram_rdata[63:32] : sram_rdata[31:0];

    // State, valid and LRU bits are the only storage cleared by reset, so
    // the cache comes back empty without touching the big arrays.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_fill) begin
                if (w_victim) begin
                    r_valid1[w_index] <= 1'b1;
                end else begin
                    r_valid0[w_index] <= 1'b1;
                end
                r_lru[w_index] <= ~w_victim;
            end else if (w_rdHit || w_wrHit) begin
                // A way0 hit makes way1 the next victim and vice versa.
                r_lru[w_index] <= w_hit0;
            end
        end
    end

    // Data and tag arrays: block fill into the victim on a read miss, or a
    // single-word update of the hitting way when a store completes.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            if (w_victim) begin
                r_data1[w_index] <= sram_rdata;
                r_tag1[w_index]  <= w_tag;
            end else begin
                r_data0[w_index] <= sram_rdata;
                r_tag0[w_index]  <= w_tag;
            end
        end else if (w_wrHit) begin
            if (w_hit0) begin
                if (w_offset) r_data0[w_index][63:32] <= wdata;
                else          r_data0[w_index][31:0]  <= wdata;
            end else begin
                if (w_offset) r_data1[w_index][63:32] <= wdata;
                else          r_data1[w_index][31:0]  <= wdata;
            end
        end
    end

    // Next-state logic. Stores take priority over loads when both are set.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (mem_wr_en) begin
                    w_nextState = WR_WAIT;
                end else if (mem_rd_en && !w_hit) begin
                    w_nextState = RD_MISS;
                end
            end
            RD_MISS: begin
                if (sram_ready) w_nextState = IDLE;
            end
            WR_WAIT: begin
                if (sram_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs. SRAM enables depend on state only; ready and rdata also look
    // at the current request so hits and fill bypass return in-cycle.
    always_comb begin
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        sram_address = address;
        sram_wdata   = wdata;
        ready        = 1'b1;
        rdata        = 32'h0;
        case (r_state)
            IDLE: begin
                if (mem_wr_en) begin
                    ready = 1'b0;
                end else if (mem_rd_en && !w_hit) begin
                    ready = 1'b0;
                end
            end
            RD_MISS: begin
                sram_rd_en   = 1'b1;
                sram_address = {address[ADDR_W-1:1], 1'b0};
                ready        = sram_ready;
            end
            WR_WAIT: begin
                sram_wr_en = 1'b1;
                ready      = sram_ready;
            end
            default: ready = 1'b1;
        endcase
        if (w_fill) begin
            rdata = w_fillWord;
        end else if (w_hit0) begin
            rdata = w_offset ? r_data0[w_index][63:32] : r_data0[w_index][31:0];
        end else if (w_hit1) begin
            rdata = w_offset ? r_data1[w_index][63:32] : r_data1[w_index][31:0];
        end
    end

endmodule
